// File: rtl/switch_debounce_fsm.sv
// ============================================================================
// switch_debounce_fsm
// ----------------------------------------------------------------------------
// Purpose:
//   Turns a raw, bouncing mechanical switch input into a clean level that
//   downstream logic (typically a rising-edge detector fed through its
//   `level` input) can trust. The pin is first brought into the clk domain
//   through a two-flop synchroniser. A four-state machine then only accepts
//   a change of level once the synchronised input has held the new value
//   for STABLE_CYCLES consecutive clocks. A one-cycle strobe is also
//   produced on every accepted press, for consumers that do not use an
//   external edge detector.
//
// Parameters:
//   STABLE_CYCLES : clocks the synchronised input must remain constant
//                   before a change is accepted (>= 1). The default gives
//                   20 ms at 100 MHz.
//
// Ports:
//   clk      : system clock; every flop updates on its rising edge.
//   reset_n  : synchronous, active-low reset, sampled on the clk edge.
//   sw       : raw asynchronous switch input; may bounce or glitch.
//   db_level : debounced level (1 while the switch is considered pressed).
//   db_tick  : one-cycle pulse coincident with the first cycle of db_level=1
//              after an accepted press; never pulses on a release or on a
//              recovery from a short low glitch.
// ============================================================================
module switch_debounce_fsm #(
    parameter int STABLE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    // Counter width is derived from the stability window so that the value
    // STABLE_CYCLES-1 always fits; it is not meant to be overridden.
    localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

    // Value loaded on entry to a WAIT state. Counting down to zero and then
    // spending one more cycle to make the decision gives a WAIT residency of
    // exactly STABLE_CYCLES clocks when the input stays put.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    // ZERO  : settled low, watching for the input to go high.
    // WAIT1 : input went high, timing how long it stays high.
    // ONE   : settled high, watching for the input to go low.
    // WAIT0 : input went low, timing how long it stays low.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sw_sync;
    logic             db_level_reg;
    logic             db_tick_reg;

    // Single sequential process holding the synchroniser, the state machine,
    // the stability counter and both registered outputs.
    //
    // The synchroniser stages shift unconditionally (outside reset) so the
    // state machine always looks at a value that has had a full clock to
    // resolve any metastability; it never sees sw directly.
    //
    // db_level is kept as its own flop rather than decoded from state_reg so
    // the pin leaving the block cannot glitch while the state bits change.
    // It is updated on exactly the transitions that move between the low
    // pair of states (ZERO/WAIT1) and the high pair (ONE/WAIT0), which keeps
    // it equal to "state is ONE or WAIT0" at all times.
    //
    // db_tick defaults low every cycle and is only raised on the
    // WAIT1->ONE decision, so it lines up with the first cycle of
    // db_level=1 and lasts exactly one clock. A return from WAIT0 to ONE is
    // a low glitch on an already-high level and deliberately produces no
    // tick.
    //
    // Every entry into a WAIT state reloads the counter, so a bounce that
    // sends the machine back to its settled state throws away any partial
    // count instead of letting it accumulate across bounces.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1        <= 1'b0;
            sw_sync      <= 1'b0;
            state_reg    <= ZERO;
            cnt          <= '0;
            db_level_reg <= 1'b0;
            db_tick_reg  <= 1'b0;
        end else begin
            sync1       <= sw;
            sw_sync     <= sync1;
            db_tick_reg <= 1'b0;

            case (state_reg)
                ZERO: begin
                    if (sw_sync) begin
                        state_reg <= WAIT1;
                        cnt       <= CNT_LOAD;
                    end
                end

                WAIT1: begin
                    if (!sw_sync) begin
                        state_reg <= ZERO;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state_reg    <= ONE;
                        db_level_reg <= 1'b1;
                        db_tick_reg  <= 1'b1;
                    end
                end

                ONE: begin
                    if (!sw_sync) begin
                        state_reg <= WAIT0;
                        cnt       <= CNT_LOAD;
                    end
                end

                WAIT0: begin
                    if (sw_sync) begin
                        state_reg <= ONE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state_reg    <= ZERO;
                        db_level_reg <= 1'b0;
                    end
                end

                // All four encodings are used today, but if the state type is
                // ever widened any stray value falls back to the safe low
                // state with a consistent output.
                default: begin
                    state_reg    <= ZERO;
                    cnt          <= '0;
                    db_level_reg <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops.
    assign db_level = db_level_reg;
    assign db_tick  = db_tick_reg;

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// ============================================================================
// tb_switch_debounce_fsm
// ----------------------------------------------------------------------------
// Self-checking bench for switch_debounce_fsm with STABLE_CYCLES=4.
// Each call to applyStimulus drives sw/reset_n for one clock, advances a
// reference model to the state the DUT should hold after that clock's
// rising edge, and pushes the expected outputs into a scoreboard queue.
// A monitor pops one entry per rising edge (sampled 1 ns after the edge)
// and compares it with the DUT outputs through checkOutput.
//
// The reference model is written as a run-length rule rather than a state
// machine: it tracks how many consecutive synchronised samples have
// disagreed with the current debounced level, and flips the level when that
// run reaches STABLE_CYCLES+1 (one cycle to notice the change plus
// STABLE_CYCLES cycles of waiting). Any agreeing sample or reset clears the
// run.
// ============================================================================
module tb_switch_debounce_fsm;

    localparam int STABLE = 4;

    logic clk;
    logic reset_n;
    logic sw;
    logic db_level;
    logic db_tick;

    switch_debounce_fsm #(
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    // 10 ns clock; stimulus changes on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  level;
        logic  tick;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    int checks_done = 0;
    int fail_count  = 0;
    int tick_count  = 0;
    string phase    = "init";

    // Reference model state, describing the DUT after the most recent edge.
    logic m_sync1 = 1'b0;
    logic m_sync  = 1'b0;
    logic m_level = 1'b0;
    int   m_run   = 0;

    // Single comparison point: counts every comparison and reports misses.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks_done++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one clock of stimulus, predicts the outputs after the coming
    // rising edge and queues them; returns once the monitor has checked them.
    task automatic applyStimulus(input logic sw_v, input logic rst_n_v);
        exp_t e;
        logic tick_n;
        @(negedge clk);
        sw      = sw_v;
        reset_n = rst_n_v;
        tick_n  = 1'b0;
        if (!rst_n_v) begin
            m_sync1 = 1'b0;
            m_sync  = 1'b0;
            m_level = 1'b0;
            m_run   = 0;
        end else begin
            if (m_sync != m_level) begin
                m_run++;
                if (m_run == STABLE + 1) begin
                    m_level = ~m_level;
                    tick_n  = m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_sync  = m_sync1;
            m_sync1 = sw_v;
        end
        e.level = m_level;
        e.tick  = tick_n;
        e.tag   = phase;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic holdFor(input logic sw_v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(sw_v, 1'b1);
    endtask

    // Monitor: one scoreboard entry is consumed per rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput({e.tag, "_level"}, int'(db_level), int'(e.level));
            checkOutput({e.tag, "_tick"},  int'(db_tick),  int'(e.tick));
            if (db_tick === 1'b1) tick_count++;
        end
    end

    initial begin
        int len;
        logic v;
        sw      = 1'b0;
        reset_n = 1'b0;

        // 1. Reset then idle.
        phase = "reset";
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        phase = "idle";
        holdFor(1'b0, 20);

        // 2. Clean press: level rises after the 7th edge, single tick.
        phase = "press";
        tick_count = 0;
        holdFor(1'b1, 6);
        checkOutput("press_not_yet", int'(db_level), 0);
        holdFor(1'b1, 1);
        checkOutput("press_level_edge7", int'(db_level), 1);
        checkOutput("press_tick_edge7", int'(db_tick), 1);
        holdFor(1'b1, 10);
        checkOutput("press_tick_count", tick_count, 1);

        // Return to low before the bouncy press.
        phase = "release1";
        holdFor(1'b0, 12);
        checkOutput("release1_level", int'(db_level), 0);

        // 3. Bouncy press, exactly one tick.
        phase = "bounce";
        tick_count = 0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        holdFor(1'b1, 12);
        checkOutput("bounce_tick_count", tick_count, 1);
        checkOutput("bounce_level", int'(db_level), 1);

        // 4. Low glitch on a held-high level, then a real release.
        phase = "glitch0";
        tick_count = 0;
        holdFor(1'b0, 2);
        holdFor(1'b1, 8);
        checkOutput("glitch0_level", int'(db_level), 1);
        phase = "release2";
        holdFor(1'b0, 6);
        checkOutput("release2_not_yet", int'(db_level), 1);
        holdFor(1'b0, 1);
        checkOutput("release2_edge7", int'(db_level), 0);
        holdFor(1'b0, 4);
        checkOutput("release_tick_count", tick_count, 0);

        // 5. Reset in the middle of WAIT1, then count from the release.
        phase = "midreset";
        tick_count = 0;
        holdFor(1'b1, 5);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midreset_level", int'(db_level), 0);
        holdFor(1'b1, 6);
        checkOutput("midreset_not_yet", int'(db_level), 0);
        holdFor(1'b1, 1);
        checkOutput("midreset_edge7", int'(db_level), 1);
        checkOutput("midreset_tick_count", tick_count, 1);
        holdFor(1'b0, 12);

        // 6. One-cycle pulse is rejected.
        phase = "pulse";
        tick_count = 0;
        applyStimulus(1'b1, 1'b1);
        holdFor(1'b0, 10);
        checkOutput("pulse_tick_count", tick_count, 0);

        // Random runs of varying length with occasional resets.
        phase = "random";
        for (int r = 0; r < 60; r++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++)
                applyStimulus(v, ($urandom_range(0, 49) != 0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        fail_count++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end

endmodule
